// File: rtl/lfsr_crypt_engine_if.sv
// Launch handshake and data-memory port between the LFSR crypt engine and its surroundings.
// master is the engine side; slave is the memory/launcher side.
interface lfsr_crypt_engine_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              req;
   logic              mode;
   logic              ack;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic [6:0]        par_err_cnt;

   modport master (
      input  req, mode, mem_rdata,
      output ack, mem_addr, mem_we, mem_wdata, par_err_cnt
   );

   modport slave (
      output req, mode, mem_rdata,
      input  ack, mem_addr, mem_we, mem_wdata, par_err_cnt
   );
endinterface

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream encrypt/decrypt sequencer working in place on the shared data memory.
// Reads pre_length/taps/seed, streams DEPTH bytes through the keystream and writes the result block.
module lfsr_crypt_engine #(
   parameter int unsigned LFSR_W    = 7,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned SRC_BASE  = 0,
   parameter int unsigned DST_BASE  = 64,
   parameter int unsigned CFG_BASE  = 61,
   parameter int unsigned PRE_MIN   = 10,
   parameter int unsigned PRE_MAX   = 26,
   parameter int unsigned PARITY_EN = 0
) (
   input  logic                clk,
   input  logic                init,
   lfsr_crypt_engine_if.master bus
);

   localparam int unsigned IDX_W   = $clog2(DEPTH + PRE_MAX + 1);
   localparam logic [6:0]  ERR_MAX = 7'h7F;

   typedef enum logic [3:0] {
      IDLE, CFG0, CFG1, CFG2, CFG3, RD, WR, TAIL, DONE
   } state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    idx, idx_nx;
   logic [7:0]          pre;
   logic [LFSR_W-1:0]   taps, lfsr, lfsr_adv, seed_val, taps_val;
   logic                dec;
   logic [6:0]          par_cnt;

   logic                ack_q, ack_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   logic [7:0]          pre_sat, s_byte, plain, cipher, enc_byte, dec_byte, wdata_c;
   logic                par_bad, last_idx, tail_last, idx_ge_pre;

   assign bus.ack         = ack_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_c;
   assign bus.par_err_cnt = par_cnt;

   // Keystream, config decoding and write-data formation from same-cycle read data
   always_comb begin
      lfsr_adv = {lfsr[LFSR_W-2:0], ^(lfsr & taps)};

      s_byte   = '0;
      seed_val = '0;
      taps_val = '0;
      for (int unsigned b = 0; b < 8 && b < LFSR_W; b++) begin
         s_byte[b]   = lfsr[b];
         seed_val[b] = bus.mem_rdata[b];
         taps_val[b] = bus.mem_rdata[b];
      end
      if (seed_val == '0) seed_val = LFSR_W'(1);

      if (bus.mem_rdata < 8'(PRE_MIN))      pre_sat = 8'(PRE_MIN);
      else if (bus.mem_rdata > 8'(PRE_MAX)) pre_sat = 8'(PRE_MAX);
      else                                  pre_sat = bus.mem_rdata;

      idx_ge_pre = (32'(idx) >= 32'(pre));
      if (!idx_ge_pre || ((32'(idx) - 32'(pre)) >= CFG_BASE)) plain = 8'h00;
      else                                                   plain = bus.mem_rdata;
      cipher   = plain ^ s_byte;
      enc_byte = {((PARITY_EN != 0) ? ^cipher[6:0] : 1'b0), cipher[6:0]};
      dec_byte = {1'b0, bus.mem_rdata[6:0] ^ s_byte[6:0]};

      if (state == WR) wdata_c = dec ? dec_byte : enc_byte;
      else             wdata_c = 8'h00;

      par_bad   = (PARITY_EN != 0) && (bus.mem_rdata[7] != ^bus.mem_rdata[6:0]);
      last_idx  = (idx == IDX_W'(DEPTH - 1));
      tail_last = (32'(idx) == (DEPTH + 32'(pre) - 1));
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state   <= IDLE;
         idx     <= '0;
         pre     <= '0;
         taps    <= '0;
         lfsr    <= '0;
         dec     <= 1'b0;
         par_cnt <= '0;
         ack_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         state  <= state_nx;
         idx    <= idx_nx;
         ack_q  <= ack_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         case (state)
            IDLE: begin
               if (!bus.req) begin
                  dec     <= bus.mode;
                  par_cnt <= '0;
               end
            end
            CFG1: pre  <= pre_sat;
            CFG2: taps <= taps_val;
            CFG3: lfsr <= seed_val;
            WR: begin
               lfsr <= lfsr_adv;
               if (dec && par_bad && (par_cnt != ERR_MAX)) par_cnt <= par_cnt + 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Next-state and index sequencing
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         IDLE: begin
            if (!bus.req) begin
               state_nx = CFG0;
               idx_nx   = '0;
            end
         end
         CFG0: state_nx = CFG1;
         CFG1: state_nx = CFG2;
         CFG2: state_nx = CFG3;
         CFG3: state_nx = RD;
         RD:   state_nx = WR;
         WR: begin
            idx_nx = idx + IDX_W'(1);
            if (last_idx) state_nx = (dec && (pre != 8'h00)) ? TAIL : DONE;
            else          state_nx = RD;
         end
         TAIL: begin
            idx_nx = idx + IDX_W'(1);
            if (tail_last) state_nx = DONE;
         end
         DONE: if (bus.req) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output values for the state being entered, so the bus shows them during that state
   always_comb begin
      addr_d = addr_q;
      we_d   = 1'b0;
      ack_d  = 1'b0;
      case (state_nx)
         CFG0: addr_d = ADDR_W'(CFG_BASE);
         CFG1: addr_d = ADDR_W'(CFG_BASE + 1);
         CFG2: addr_d = ADDR_W'(CFG_BASE + 2);
         RD: begin
            if (dec) addr_d = ADDR_W'(SRC_BASE) + ADDR_W'(idx_nx);
            else     addr_d = ADDR_W'(SRC_BASE) + ADDR_W'(idx_nx) - ADDR_W'(pre);
         end
         WR: begin
            if (dec) addr_d = ADDR_W'(DST_BASE) + ADDR_W'(idx_nx) - ADDR_W'(pre);
            else     addr_d = ADDR_W'(DST_BASE) + ADDR_W'(idx_nx);
            we_d = !dec || (32'(idx_nx) >= 32'(pre));
         end
         TAIL: begin
            addr_d = ADDR_W'(DST_BASE) + ADDR_W'(idx_nx) - ADDR_W'(pre);
            we_d   = 1'b1;
         end
         DONE: ack_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench for lfsr_crypt_engine: parity-off and parity-on instances run side by side,
// each against its own synchronous-read memory.
module tb_lfsr_crypt_engine;

   logic clk  = 1'b0;
   logic init = 1'b0;
   logic req  = 1'b1;
   logic mode = 1'b0;

   logic       bk_we = 1'b0, bk_fill = 1'b0, bk_copy = 1'b0, bk_flip = 1'b0, bk_zero = 1'b0;
   logic [7:0] bk_addr = 8'h00, bk_data = 8'h00;

   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];
   int         wr0 = 0, wr1 = 0;
   int         checks = 0, errors = 0;

   string      msg = "Mr. Watson, come here. I want to see you.";
   logic [7:0] ks [8];

   always #5 clk = ~clk;

   lfsr_crypt_engine_if #(.ADDR_W(8)) bus0 ();
   lfsr_crypt_engine_if #(.ADDR_W(8)) bus1 ();

   assign bus0.req  = req;
   assign bus1.req  = req;
   assign bus0.mode = mode;
   assign bus1.mode = mode;

   lfsr_crypt_engine #(.PARITY_EN(0)) dut0 (.clk(clk), .init(init), .bus(bus0.master));
   lfsr_crypt_engine #(.PARITY_EN(1)) dut1 (.clk(clk), .init(init), .bus(bus1.master));

   // Memories plus bench-side bulk operations, all in one process
   always @(posedge clk) begin
      if (bus0.mem_we) begin mem0[bus0.mem_addr] <= bus0.mem_wdata; wr0 <= wr0 + 1; end
      if (bus1.mem_we) begin mem1[bus1.mem_addr] <= bus1.mem_wdata; wr1 <= wr1 + 1; end
      bus0.mem_rdata <= mem0[bus0.mem_addr];
      bus1.mem_rdata <= mem1[bus1.mem_addr];
      if (bk_zero) for (int k = 0; k < 256; k++) begin mem0[k] <= 8'h00; mem1[k] <= 8'h00; end
      if (bk_fill) for (int k = 64; k < 128; k++) begin mem0[k] <= bk_data; mem1[k] <= bk_data; end
      if (bk_copy) for (int k = 0; k < 61; k++) begin mem0[k] <= mem0[k+64]; mem1[k] <= mem1[k+64]; end
      if (bk_we) begin mem0[bk_addr] <= bk_data; mem1[bk_addr] <= bk_data; end
      if (bk_flip) begin mem0[bk_addr] <= mem0[bk_addr] ^ 8'h80; mem1[bk_addr] <= mem1[bk_addr] ^ 8'h80; end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bk_write(input logic [7:0] a, input logic [7:0] d);
      bk_addr = a; bk_data = d; bk_we = 1'b1; tick(); bk_we = 1'b0;
   endtask

   task automatic bk_flip_at(input logic [7:0] a);
      bk_addr = a; bk_flip = 1'b1; tick(); bk_flip = 1'b0;
   endtask

   task automatic bk_fill_dst(input logic [7:0] d);
      bk_data = d; bk_fill = 1'b1; tick(); bk_fill = 1'b0;
   endtask

   task automatic bk_copy_src();
      bk_copy = 1'b1; tick(); bk_copy = 1'b0;
   endtask

   task automatic bk_clear();
      bk_zero = 1'b1; tick(); bk_zero = 1'b0;
   endtask

   task automatic set_cfg(input logic [7:0] p, input logic [7:0] t, input logic [7:0] s);
      bk_write(8'd61, p); bk_write(8'd62, t); bk_write(8'd63, s);
   endtask

   // One full launch/complete/release cycle; latency counted in edges from driving req low
   task automatic run(input logic m, input int exp_lat, input string tag);
      int n;
      int w0;
      w0   = wr0;
      mode = m;
      req  = 1'b0;
      n    = 0;
      do begin
         tick();
         n++;
         if (n == 10) mode = ~m;
      end while (!bus0.ack && n < 400);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_ack1"}, bus1.ack, 1);
      repeat (3) tick();
      check({tag, "_hold"}, bus0.ack, 1);
      check({tag, "_wr"}, wr0 - w0, 64);
      req = 1'b1;
      tick();
      check({tag, "_ackclr"}, bus0.ack, 0);
   endtask

   task automatic check_ks(input string tag);
      for (int k = 0; k < 8; k++) check($sformatf("%s_ks%0d", tag, k), mem0[64+k], ks[k]);
   endtask

   task automatic check_msg(input string tag);
      for (int k = 0; k < 41; k++) begin
         check($sformatf("%s_p0_%0d", tag, k), mem0[64+k], 8'(msg[k] - 8'h20));
         check($sformatf("%s_p1_%0d", tag, k), mem1[64+k], 8'(msg[k] - 8'h20));
      end
   endtask

   initial begin
      int n;
      ks = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};

      #1 init = 1'b1;
      tick();
      check("rst_ack",   bus0.ack, 0);
      check("rst_we",    bus0.mem_we, 0);
      check("rst_addr",  bus0.mem_addr, 0);
      check("rst_wdata", bus0.mem_wdata, 0);
      check("rst_perr",  bus1.par_err_cnt, 0);
      bk_clear();
      init = 1'b0;
      tick();

      // Zero message: output is the raw keystream
      set_cfg(8'd10, 8'h60, 8'h01);
      run(1'b0, 133, "enc");
      check_ks("enc");
      check("par64", mem1[64], 8'h81);
      check("par65", mem1[65], 8'h82);
      check("par70", mem1[70], 8'h41);
      check("par71", mem1[71], 8'h03);

      // Saturated pre_length and zero seed
      bk_fill_dst(8'hEE);
      set_cfg(8'd5, 8'h60, 8'h00);
      run(1'b0, 133, "sat");
      check_ks("sat");
      run(1'b1, 143, "dec5");
      bk_fill_dst(8'hEE);
      set_cfg(8'd40, 8'h60, 8'h00);
      run(1'b1, 159, "dec40");
      check("tail_first", mem0[102], 8'h00);
      check("tail_last",  mem0[127], 8'h00);

      // Round trip of the biased message
      bk_clear();
      for (int k = 0; k < 41; k++) bk_write(8'(k), 8'(msg[k] - 8'h20));
      set_cfg(8'd10, 8'h48, 8'h03);
      run(1'b0, 133, "rt_enc");
      bk_copy_src();
      bk_fill_dst(8'hEE);
      run(1'b1, 143, "rt_dec");
      check_msg("rt");
      // 115..117 decode the config bytes that sit in the source window
      for (int k = 105; k < 128; k++) begin
         if (k < 115 || k > 117) begin
            check($sformatf("rt_z0_%0d", k), mem0[k], 8'h00);
            check($sformatf("rt_z1_%0d", k), mem1[k], 8'h00);
         end
      end
      check("rt_perr0", bus0.par_err_cnt, 0);
      check("rt_perr1", bus1.par_err_cnt, 0);

      // Corrupted parity on three ciphertext bytes
      bk_flip_at(8'd12);
      bk_flip_at(8'd30);
      bk_flip_at(8'd45);
      bk_fill_dst(8'hEE);
      run(1'b1, 143, "perr");
      check("perr_cnt1", bus1.par_err_cnt, 3);
      check("perr_cnt0", bus0.par_err_cnt, 0);
      check_msg("perr");

      // Abort with reset during the write of index 20, then relaunch
      bk_clear();
      set_cfg(8'd10, 8'h60, 8'h01);
      bk_fill_dst(8'hEE);
      mode = 1'b0;
      req  = 1'b0;
      n    = 0;
      do begin
         tick();
         n++;
      end while (!(bus0.mem_we && bus0.mem_addr == 8'd84) && n < 300);
      check("abort_at", n, 46);
      init = 1'b1;
      #1;
      check("abort_ack",  bus0.ack, 0);
      check("abort_we",   bus0.mem_we, 0);
      check("abort_addr", bus0.mem_addr, 0);
      check("abort_we1",  bus1.mem_we, 0);
      req = 1'b1;
      tick();
      init = 1'b0;
      tick();
      check("abort_kept", mem0[71], 8'h03);
      check("abort_skip", mem0[84], 8'hEE);
      bk_fill_dst(8'hEE);
      run(1'b0, 133, "relaunch");
      check_ks("relaunch");
      check("relaunch_par71", mem1[71], 8'h03);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_crypt_engine.md
Name: lfsr_crypt_engine

Overview:
- Hardware replacement for the software encrypt program: a sequencer that runs LFSR stream encryption or decryption against the shared data memory.
- Reads its configuration and message, and writes the result back.
- Sits beside data memory under top_level and uses the same req/ack launch protocol as the processor.
- Generalises the fixed 7-bit / 64-byte / parity-off program: LFSR width, block depth, memory map and parity are parameters, and a mode input adds decryption with parity checking.

Parameters:
LFSR_W, 7, LFSR state width; state and tap values are masked to LFSR_W bits
DEPTH, 64, output block length in bytes
ADDR_W, 8, memory address width
SRC_BASE, 0, first source byte address
DST_BASE, 64, first destination byte address
CFG_BASE, 61, address of pre_length; taps at CFG_BASE+1, seed at CFG_BASE+2
PRE_MIN, 10, lower saturation bound for pre_length
PRE_MAX, 26, upper saturation bound for pre_length
PARITY_EN, 0, 1 = bit7 carries even parity of bits[6:0]

Ports:
clk  in  1  clock, rising edge
init  in  1  asynchronous active-high reset
req  in  1  1 = hold in IDLE; first cycle sampled 0 in IDLE launches a run
mode  in  1  0 = encrypt, 1 = decrypt; sampled at launch
ack  out  1  run complete; held until req returns to 1
mem_addr  out  ADDR_W  memory address
mem_we  out  1  write strobe
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid the cycle after mem_addr is presented
par_err_cnt  out  7  decrypt parity mismatches, saturating at 127

Behaviour:
- Reset: on init=1, asynchronously go to IDLE with ack=0, mem_we=0, mem_addr=0, mem_wdata=0, par_err_cnt=0. A reset mid-run aborts the run; memory writes already issued remain.
- States are IDLE, CFG0..CFG3, RD, WR, TAIL and DONE.
- IDLE: when req=0, latch mode, clear par_err_cnt and i, then go to CFG0.
- CFG0..CFG3: present CFG_BASE, +1 and +2 on CFG0..CFG2. Capture pre on CFG1, taps on CFG2 and seed on CFG3.
  - pre saturates to [PRE_MIN, PRE_MAX].
  - A seed of 0 is replaced by 1.
- RD/WR loop: i runs from 0 to DEPTH-1 at 2 cycles per index. RD presents the read address; WR consumes mem_rdata, writes, advances the LFSR and increments i.
- LFSR update: next = {state[LFSR_W-2:0], ^(state & taps)}. Index i uses state s_i, where s_0 = seed.
- Encrypt, per index i:
  - Read address is SRC_BASE+(i-pre).
  - plain = 0 when i<pre or (i-pre) ≥ CFG_BASE; otherwise plain = mem_rdata.
  - c = plain ^ s_i.
  - Write to DST_BASE+i: bit7 = (PARITY_EN ? ^c[6:0] : 0), bits[6:0] = c[6:0].
- Decrypt, per index i:
  - Read address is SRC_BASE+i.
  - If PARITY_EN and mem_rdata[7] ≠ ^mem_rdata[6:0], increment par_err_cnt (saturating).
  - When i ≥ pre, write {0, mem_rdata[6:0]^s_i[6:0]} to DST_BASE+(i-pre). When i<pre, issue no write.
  - After the loop, TAIL writes 0 to DST_BASE+DEPTH-pre .. DST_BASE+DEPTH-1, one byte per cycle.
- Latency from the launch cycle to ack rising: encrypt takes exactly 5+2·DEPTH cycles (133 at defaults); decrypt takes 5+2·DEPTH+pre.
- DONE: ack=1 and mem_we=0. Return to IDLE only when req=1. A req=0 held in DONE does not relaunch.
- mode changes mid-run are ignored.
- mem_we is asserted only in WR and TAIL.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- Encrypt, taps 0x60, seed 0x01, pre 10, zero message, PARITY_EN=0 -> mem[64..71] = 01,02,04,08,10,20,41,03; ack rises exactly 133 cycles after launch.
- Same stimulus with PARITY_EN=1 -> mem[64]=0x81, mem[65]=0x82, mem[70]=0x41, mem[71]=0x03.
- Round trip: "Mr. Watson, come here. I want to see you." minus 0x20 with pre 10 and taps 0x48, encrypted then decrypted -> mem[64..104] equals the original biased string, remaining bytes 0, par_err_cnt=0.
- Decrypt with PARITY_EN=1 and the bit7 of 3 ciphertext bytes flipped -> par_err_cnt=3; plaintext is unchanged.
- pre=5 and seed=0 -> behaves identically to pre=10, seed=1; pre=40 behaves as 26.
- Assert init for 1 cycle during the WR at i=20 -> ack=0 and mem_we=0 immediately. A relaunch produces a correct full block.
